xor_memory_arbiter: RTL and testbench

- Shares one `xor_memory` instance (PORTS read/write ports, no reset) among REQS requesters.
- Each cycle it grants up to PORTS requests in round-robin order and maps the k-th grant onto memory port k.
- It enforces the xor_memory hazard rules: no same-address writes in one cycle, and no reads of an address whose write has not yet committed.
- It returns read data to the issuing requester one cycle after grant.

---
 rtl/xor_memory_arbiter.sv | 170 +++++++++++++++++
 tb/tb_xor_memory_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : xor_memory_arbiter
//  Purpose  : Round-robin arbiter sharing one multi-port xor_memory among
//             several requesters, enforcing its write/read hazard rules.
//  Revision : 1.0  initial release
// ============================================================================
module xor_memory_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int PORTS = 2,
    parameter int REQS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REQS-1:0]          req_valid,
    input  logic [REQS-1:0]          req_we,
    input  logic [$clog2(DEPTH)-1:0] req_addr [REQS],
    input  logic [WIDTH-1:0]         req_d    [REQS],
    output logic [REQS-1:0]          req_ready,
    output logic [REQS-1:0]          rsp_valid,
    output logic [WIDTH-1:0]         rsp_data [REQS],
    output logic [$clog2(DEPTH)-1:0] mem_addr [PORTS],
    output logic [WIDTH-1:0]         mem_d    [PORTS],
    output logic [PORTS-1:0]         mem_en,
    input  logic [WIDTH-1:0]         mem_q    [PORTS],
    output logic [15:0]              conflict_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = (REQS > 1) ? $clog2(REQS) : 1;

    // Registered state
    logic [RW-1:0]    rr_ptr_q;
    logic [RW-1:0]    rr_ptr_d;
    logic [PORTS-1:0] hist_v_q;
    logic [AW-1:0]    hist_addr_q [PORTS];
    logic [PORTS-1:0] pend_v_q;
    logic [RW-1:0]    pend_req_q  [PORTS];
    logic [WIDTH-1:0] rsp_data_q  [REQS];
    logic [15:0]      conflict_q;
    logic [15:0]      conflict_d;

    // Arbitration scratch
    logic [RW-1:0]    w_scan;
    logic [RW-1:0]    w_last;
    logic             w_blk;
    logic             w_hazard;
    logic             w_any_grant;
    logic [PORTS-1:0] w_port_rd;
    logic [RW-1:0]    w_port_req [PORTS];
    int               ngrant_i;
    int               scan_i;

    // Round-robin scan; the k-th grant lands on memory port k.
    always_comb begin
        req_ready   = '0;
        w_scan      = rr_ptr_q;
        w_last      = rr_ptr_q;
        w_blk       = 1'b0;
        w_hazard    = 1'b0;
        w_any_grant = 1'b0;
        w_port_rd   = '0;
        mem_en      = '0;
        ngrant_i    = 0;
        scan_i      = 0;
        for (int p = 0; p < PORTS; p++) begin
            mem_addr[p]   = '0;
            mem_d[p]      = '0;
            w_port_req[p] = '0;
        end
        for (int k = 0; k < REQS; k++) begin
            scan_i = int'(rr_ptr_q) + k;
            if (scan_i >= REQS) begin
                scan_i = scan_i - REQS;
            end
            w_scan = RW'(scan_i);
            w_blk  = 1'b0;
            // Blocked by last cycle's uncommitted writes or an earlier write in this scan
            for (int p = 0; p < PORTS; p++) begin
                if (hist_v_q[p] && (hist_addr_q[p] == req_addr[w_scan])) begin
                    w_blk = 1'b1;
                end
                if ((p < ngrant_i) && mem_en[p] && (mem_addr[p] == req_addr[w_scan])) begin
                    w_blk = 1'b1;
                end
            end
            if (!rst && req_valid[w_scan] && (ngrant_i < PORTS)) begin
                if (w_blk) begin
                    w_hazard = 1'b1;
                end else begin
                    req_ready[w_scan] = 1'b1;
                    w_any_grant       = 1'b1;
                    w_last            = w_scan;
                    for (int p = 0; p < PORTS; p++) begin
                        if (p == ngrant_i) begin
                            mem_addr[p]   = req_addr[w_scan];
                            mem_d[p]      = req_d[w_scan];
                            mem_en[p]     = req_we[w_scan];
                            w_port_rd[p]  = ~req_we[w_scan];
                            w_port_req[p] = w_scan;
                        end
                    end
                    ngrant_i = ngrant_i + 1;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_any_grant) begin
            rr_ptr_d = (int'(w_last) == REQS - 1) ? '0 : w_last + RW'(1);
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (w_hazard && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // Read data is steered straight from mem_q in the cycle after grant
    always_comb begin
        rsp_valid = '0;
        for (int r = 0; r < REQS; r++) begin
            rsp_data[r] = rsp_data_q[r];
        end
        for (int p = 0; p < PORTS; p++) begin
            if (pend_v_q[p]) begin
                rsp_valid[pend_req_q[p]] = 1'b1;
                rsp_data[pend_req_q[p]]  = mem_q[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            hist_v_q   <= '0;
            pend_v_q   <= '0;
            conflict_q <= '0;
            for (int p = 0; p < PORTS; p++) begin
                hist_addr_q[p] <= '0;
                pend_req_q[p]  <= '0;
            end
            for (int r = 0; r < REQS; r++) begin
                rsp_data_q[r] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            hist_v_q   <= mem_en;
            pend_v_q   <= w_port_rd;
            conflict_q <= conflict_d;
            for (int p = 0; p < PORTS; p++) begin
                hist_addr_q[p] <= mem_addr[p];
                pend_req_q[p]  <= w_port_req[p];
            end
            for (int r = 0; r < REQS; r++) begin
                rsp_data_q[r] <= rsp_data[r];
            end
        end
    end

    assign conflict_cnt = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_xor_memory_arbiter
//  Purpose  : Directed self-checking bench with a behavioural memory and
//             an arbitration reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xor_memory_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int PORTS = 2;
    localparam int REQS  = 4;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [REQS-1:0]  req_valid;
    logic [REQS-1:0]  req_we;
    logic [AW-1:0]    req_addr [REQS];
    logic [WIDTH-1:0] req_d    [REQS];
    logic [REQS-1:0]  req_ready;
    logic [REQS-1:0]  rsp_valid;
    logic [WIDTH-1:0] rsp_data [REQS];
    logic [AW-1:0]    mem_addr [PORTS];
    logic [WIDTH-1:0] mem_d    [PORTS];
    logic [PORTS-1:0] mem_en;
    logic [WIDTH-1:0] mem_q    [PORTS];
    logic [15:0]      conflict_cnt;

    always #5 clk = ~clk;

    xor_memory_arbiter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PORTS (PORTS),
        .REQS  (REQS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_d        (req_d),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .mem_addr     (mem_addr),
        .mem_d        (mem_d),
        .mem_en       (mem_en),
        .mem_q        (mem_q),
        .conflict_cnt (conflict_cnt)
    );

    // Behavioural xor_memory: read data next cycle, write commits one cycle late
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PORTS-1:0] wp_v;
    logic [AW-1:0]    wp_a [PORTS];
    logic [WIDTH-1:0] wp_d [PORTS];
    logic             pl_v;
    logic [AW-1:0]    pl_a;
    logic [WIDTH-1:0] pl_d;

    always @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            mem_q[p] <= mem[mem_addr[p]];
            if (wp_v[p]) mem[wp_a[p]] <= wp_d[p];
            wp_v[p] <= mem_en[p];
            wp_a[p] <= mem_addr[p];
            wp_d[p] <= mem_d[p];
        end
        if (pl_v) mem[pl_a] <= pl_d;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [WIDTH-1:0] m_mem  [DEPTH];
    logic [AW-1:0]    m_hist [$];
    int               m_rr;
    int               m_cnt;
    bit               m_pv   [REQS];
    logic [WIDTH-1:0] m_pd   [REQS];
    logic [WIDTH-1:0] m_last [REQS];
    int               g_r    [$];
    logic [REQS-1:0]  e_ready;
    logic [WIDTH-1:0] e_data;
    bit               hz;
    bit               blk;
    int               r;
    int               g;

    always @(negedge clk) begin
        if (pl_v) m_mem[pl_a] = pl_d;
        if (rst) begin
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_mem_en", 32'(mem_en), 32'h0);
            chk("rst_conflict_cnt", 32'(conflict_cnt), 32'h0);
            for (int p = 0; p < PORTS; p++) begin
                chk("rst_mem_addr", 32'(mem_addr[p]), 32'h0);
                chk("rst_mem_d", 32'(mem_d[p]), 32'h0);
            end
            for (int i = 0; i < REQS; i++) begin
                chk("rst_rsp_data", 32'(rsp_data[i]), 32'h0);
                m_pv[i]   = 1'b0;
                m_last[i] = '0;
            end
            m_rr  = 0;
            m_cnt = 0;
            m_hist.delete();
        end else begin
            g_r.delete();
            e_ready = '0;
            hz      = 1'b0;
            for (int k = 0; k < REQS; k++) begin
                r = (m_rr + k) % REQS;
                if (req_valid[r] && g_r.size() < PORTS) begin
                    blk = 1'b0;
                    foreach (m_hist[i]) if (m_hist[i] == req_addr[r]) blk = 1'b1;
                    foreach (g_r[i]) if (req_we[g_r[i]] && req_addr[g_r[i]] == req_addr[r]) blk = 1'b1;
                    if (blk) hz = 1'b1;
                    else begin
                        g_r.push_back(r);
                        e_ready[r] = 1'b1;
                    end
                end
            end
            chk("m_ready", 32'(req_ready), 32'(e_ready));
            for (int p = 0; p < PORTS; p++) begin
                if (p < g_r.size()) begin
                    g = g_r[p];
                    chk("m_mem_addr", 32'(mem_addr[p]), 32'(req_addr[g]));
                    chk("m_mem_d", 32'(mem_d[p]), 32'(req_d[g]));
                    chk("m_mem_en", 32'(mem_en[p]), 32'(req_we[g]));
                end else begin
                    chk("m_idle_addr", 32'(mem_addr[p]), 32'h0);
                    chk("m_idle_d", 32'(mem_d[p]), 32'h0);
                    chk("m_idle_en", 32'(mem_en[p]), 32'h0);
                end
            end
            for (int i = 0; i < REQS; i++) begin
                e_data = m_pv[i] ? m_pd[i] : m_last[i];
                chk("m_rsp_valid", 32'(rsp_valid[i]), 32'(m_pv[i]));
                chk("m_rsp_data", 32'(rsp_data[i]), 32'(e_data));
                m_last[i] = e_data;
                m_pv[i]   = 1'b0;
            end
            chk("m_conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
            if (hz && m_cnt < 65535) m_cnt++;
            m_hist.delete();
            foreach (g_r[i]) begin
                if (!req_we[g_r[i]]) begin
                    m_pv[g_r[i]] = 1'b1;
                    m_pd[g_r[i]] = m_mem[req_addr[g_r[i]]];
                end
            end
            foreach (g_r[i]) begin
                if (req_we[g_r[i]]) begin
                    m_mem[req_addr[g_r[i]]] = req_d[g_r[i]];
                    m_hist.push_back(req_addr[g_r[i]]);
                end
            end
            if (g_r.size() > 0) m_rr = (g_r[g_r.size()-1] + 1) % REQS;
        end
    end

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        logic [REQS-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            settle();
            advance();
        end
    endtask

    task automatic issue(input int rq, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_valid[rq] = 1'b1;
        req_we[rq]    = we;
        req_addr[rq]  = a;
        req_d[rq]     = d;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (req_valid != '0 && i < budget) begin
            settle();
            advance();
            i++;
        end
        chk("drain_timeout", 32'(req_valid), 32'h0);
        idle(2);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        pl_v = 1'b1;
        pl_a = a;
        pl_d = d;
        @(negedge clk);
        @(posedge clk);
        #1;
        pl_v = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        pl_v      = 1'b0;
        pl_a      = '0;
        pl_d      = '0;
        for (int i = 0; i < REQS; i++) begin
            req_addr[i] = '0;
            req_d[i]    = '0;
        end
        preload(8'h10, 8'h5A);
        preload(8'h01, 8'hC1);
        preload(8'h02, 8'hC2);
        preload(8'h03, 8'hC3);
        preload(8'h04, 8'hC4);
        preload(8'h40, 8'h07);
        settle();
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_mem_en", 32'(mem_en), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read
        issue(0, 1'b0, 8'h10, 8'h00);
        settle();
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_port0_addr", 32'(mem_addr[0]), 32'h10);
        advance();
        settle();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data", 32'(rsp_data[0]), 32'h5A);
        advance();
        issue(3, 1'b0, 8'h10, 8'h00);
        settle();
        chk("t1b_ready", 32'(req_ready), 32'h8);
        advance();
        settle();
        chk("t1b_rsp_data", 32'(rsp_data[3]), 32'h5A);
        advance();

        // Four reads from rr_ptr = 0
        for (int i = 0; i < REQS; i++) issue(i, 1'b0, AW'(i + 1), 8'h00);
        settle();
        chk("t2_ready_a", 32'(req_ready), 32'h3);
        chk("t2_port0_addr", 32'(mem_addr[0]), 32'h01);
        chk("t2_port1_addr", 32'(mem_addr[1]), 32'h02);
        advance();
        settle();
        chk("t2_ready_b", 32'(req_ready), 32'hC);
        chk("t2_rsp_valid_a", 32'(rsp_valid), 32'h3);
        chk("t2_rsp_data0", 32'(rsp_data[0]), 32'hC1);
        chk("t2_rsp_data1", 32'(rsp_data[1]), 32'hC2);
        advance();
        settle();
        chk("t2_rsp_valid_b", 32'(rsp_valid), 32'hC);
        chk("t2_rsp_data2", 32'(rsp_data[2]), 32'hC3);
        chk("t2_rsp_data3", 32'(rsp_data[3]), 32'hC4);
        advance();

        // Same-address writes serialize
        issue(1, 1'b1, 8'h20, 8'hAA);
        issue(2, 1'b1, 8'h20, 8'hBB);
        settle();
        chk("t3_ready_a", 32'(req_ready), 32'h2);
        chk("t3_cnt_a", 32'(conflict_cnt), 32'd0);
        advance();
        settle();
        chk("t3_ready_b", 32'(req_ready), 32'h0);
        chk("t3_cnt_b", 32'(conflict_cnt), 32'd1);
        advance();
        settle();
        chk("t3_ready_c", 32'(req_ready), 32'h4);
        chk("t3_cnt_c", 32'(conflict_cnt), 32'd2);
        advance();
        drain(10);
        issue(0, 1'b0, 8'h20, 8'h00);
        settle();
        chk("t3_read_ready", 32'(req_ready), 32'h1);
        advance();
        settle();
        chk("t3_read_data", 32'(rsp_data[0]), 32'hBB);
        advance();

        // Read-after-write is held one cycle
        issue(0, 1'b1, 8'h30, 8'h11);
        settle();
        chk("t4_wr_ready", 32'(req_ready), 32'h1);
        advance();
        issue(1, 1'b0, 8'h30, 8'h00);
        settle();
        chk("t4_rd_held", 32'(req_ready), 32'h0);
        advance();
        settle();
        chk("t4_rd_ready", 32'(req_ready), 32'h2);
        chk("t4_cnt", 32'(conflict_cnt), 32'd3);
        advance();
        settle();
        chk("t4_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("t4_rsp_data", 32'(rsp_data[1]), 32'h11);
        advance();

        // Same-scan read then write
        issue(2, 1'b0, 8'h40, 8'h00);
        issue(3, 1'b1, 8'h40, 8'h99);
        settle();
        chk("t5_ready", 32'(req_ready), 32'hC);
        chk("t5_mem_en", 32'(mem_en), 32'h2);
        advance();
        settle();
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t5_rsp_old", 32'(rsp_data[2]), 32'h07);
        advance();
        idle(1);
        issue(0, 1'b0, 8'h40, 8'h00);
        settle();
        chk("t5_read_ready", 32'(req_ready), 32'h1);
        advance();
        settle();
        chk("t5_rsp_new", 32'(rsp_data[0]), 32'h99);
        advance();

        // Reset while a response is pending
        issue(1, 1'b0, 8'h10, 8'h00);
        settle();
        chk("t6_ready", 32'(req_ready), 32'h2);
        advance();
        rst = 1'b1;
        settle();
        chk("t6_rsp_dropped", 32'(rsp_valid), 32'h0);
        chk("t6_cnt_cleared", 32'(conflict_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1, 1'b0, 8'h01, 8'h00);
        issue(2, 1'b0, 8'h02, 8'h00);
        issue(3, 1'b0, 8'h03, 8'h00);
        settle();
        chk("t6_rr_reset", 32'(req_ready), 32'h6);
        advance();
        settle();
        chk("t6_ready_b", 32'(req_ready), 32'h8);
        chk("t6_rsp_data1", 32'(rsp_data[1]), 32'hC1);
        chk("t6_rsp_data2", 32'(rsp_data[2]), 32'hC2);
        advance();
        settle();
        chk("t6_rsp_data3", 32'(rsp_data[3]), 32'hC3);
        advance();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
